// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
// Optional feature macro: MULDIV_EARLY_OUT_EN (see muldiv_seq_ctrl).
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  localparam logic OP_MUL = 1'b1;
  localparam logic OP_DIV = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of shift-add multiply
// or restoring divide. Owns the adder and the subtractor.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0]   a_n,
  output logic [WIDTH-1:0]   b_n
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_ext;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH:0] wide;

  // Next accumulator/operand values for a single iteration
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]}
            + (b[0] ? {1'b0, a} : '0);
    rem_ext = {acc[2*WIDTH-1:WIDTH], a[WIDTH-1]};
    diff    = rem_ext - {1'b0, b};
    wide    = {sum, acc[WIDTH-1:0]};
    acc_n   = acc;
    a_n     = a;
    b_n     = b;
    if (op == OP_MUL) begin
      acc_n = wide[2*WIDTH:1];
      b_n   = b >> 1;
    end else begin
      a_n = a << 1;
      if (!diff[WIDTH]) begin
        acc_n = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = {rem_ext[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// muldiv_seq_ctrl: FSM, counter and start/busy/done handshake around muldiv_step.
// Define MULDIV_EARLY_OUT_EN to finish multiplies once the multiplier runs out of ones.
module muldiv_seq_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               dbz_q, dbz_d;

  logic [2*WIDTH-1:0] acc_n;
  logic [WIDTH-1:0]   a_n;
  logic [WIDTH-1:0]   b_n;

`ifdef MULDIV_EARLY_OUT_EN
  logic [CNT_W-1:0]   sh_left;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op    (op_q),
    .acc   (acc_q),
    .a     (a_q),
    .b     (b_q),
    .acc_n (acc_n),
    .a_n   (a_n),
    .b_n   (b_n)
  );

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
    sh_left = CNT_W'(WIDTH - 1) - cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = x;
          b_d     = y;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
          if (op == OP_DIV && y == '0) begin
            acc_d   = {x, {WIDTH{1'b1}}};
            state_d = FIN;
          end
`ifdef MULDIV_EARLY_OUT_EN
          else if (op == OP_MUL && y == '0) begin
            state_d = FIN;
          end
`endif
        end
      end
      RUN: begin
        acc_d = acc_n;
        a_d   = a_n;
        b_d   = b_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIN;
        end
`ifdef MULDIV_EARLY_OUT_EN
        if (op_q == OP_MUL && b_n == '0) begin
          acc_d   = acc_n >> sh_left;
          state_d = FIN;
        end
`endif
      end
      FIN: begin
        done_d  = 1'b1;
        res_d   = acc_q;
        dbz_d   = (op_q == OP_DIV) && (b_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  // State and output registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = res_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// tb_muldiv_seq_ctrl: vector table, corner sequences and random ops
// against an arithmetic reference model.
module tb_muldiv_seq_ctrl;

  localparam int W = 32;

  typedef struct {
    logic        op;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] res;
    logic        dbz;
  } vec_t;

  logic          clk = 1'b0;
  logic          clear;
  logic          start;
  logic          op;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic          busy;
  logic          done;
  logic [2*W-1:0] result;
  logic          dbz;

  int checks = 0;
  int errors = 0;
  logic [63:0] prev;

  always #5 clk = ~clk;

  muldiv_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .x           (x),
    .y           (y),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (dbz)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    if (o) return {32'b0, a} * {32'b0, b};
    if (b == 0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  // Cycles from the start edge to the cycle where done is seen
  function automatic int model_lat(input logic o, input logic [31:0] b);
    int msb;
    if (!o && b == 0) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (o) begin
      if (b == 0) return 1;
      msb = 0;
      for (int i = 0; i < 32; i++) if (b[i]) msb = i;
      return msb + 2;
    end
`else
    msb = 0;
`endif
    return W + 1;
  endfunction

  task automatic run_op(input logic o, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    int lat;
    int bc;
    logic [63:0] exp;
    exp = model(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; x = a; y = b;
    @(posedge clk); #1;
    start = 1'b0;
    op = 1'($urandom); x = $urandom; y = $urandom;
    chk({tag, " hold"}, result, prev);
    lat = 0;
    bc = int'(busy);
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      bc += int'(busy);
    end
    chk({tag, " latency"}, 64'(lat), 64'(model_lat(o, b)));
    chk({tag, " busy_cycles"}, 64'(bc), 64'(model_lat(o, b) - 1));
    chk({tag, " result"}, result, exp);
    chk({tag, " dbz"}, 64'(dbz), 64'(!o && b == 0));
    prev = exp;
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 64'(done), 64'(0));
    chk({tag, " result_kept"}, result, exp);
  endtask

  vec_t vt[9];

  initial begin
    int n;
    logic o;
    logic [31:0] a, b;

    vt[0] = '{1'b1, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0};
    vt[1] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              64'hFFFF_FFFE_0000_0001, 1'b0};
    vt[2] = '{1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0};
    vt[3] = '{1'b0, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1'b1};
    vt[4] = '{1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0};
    vt[5] = '{1'b1, 32'd12345, 32'd0, 64'h0, 1'b0};
    vt[6] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, 1'b0};
    vt[7] = '{1'b0, 32'd6, 32'd9, 64'h0000_0006_0000_0000, 1'b0};
    vt[8] = '{1'b0, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF, 1'b1};

    clear = 1'b1; start = 1'b0; op = 1'b0; x = '0; y = '0;
    prev = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst result", result, 64'h0);
    chk("rst dbz", 64'(dbz), 64'(0));

    @(negedge clk);
    start = 1'b1; op = 1'b1; x = 32'd3; y = 32'd5;
    @(posedge clk); #1;
    chk("clear_wins busy", 64'(busy), 64'(0));
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("clear_wins no_done", 64'(done), 64'(0));

    for (int i = 0; i < 9; i++) begin
      chk($sformatf("vec%0d model", i), model(vt[i].op, vt[i].x, vt[i].y),
          vt[i].res);
      run_op(vt[i].op, vt[i].x, vt[i].y, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table_res", i), result, vt[i].res);
      chk($sformatf("vec%0d table_dbz", i), 64'(dbz), 64'(vt[i].dbz));
    end

    // Abort a divide at iteration 10
    @(negedge clk);
    start = 1'b1; op = 1'b0; x = 32'd100; y = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort result", result, 64'h0);
    chk("abort dbz", 64'(dbz), 64'(0));
    @(negedge clk);
    clear = 1'b0;
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("abort no_done", 64'(n), 64'(0));
    prev = '0;
    run_op(1'b1, 32'd3, 32'd5, "after_abort");

    // Second start while busy is dropped
    @(negedge clk);
    start = 1'b1; op = 1'b0; x = 32'd100; y = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 1'b1; x = 32'd9; y = 32'd9;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    repeat (45) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("busy_start pulses", 64'(n), 64'(1));
    chk("busy_start result", result, 64'h0000_0002_0000_000E);
    chk("busy_start dbz", 64'(dbz), 64'(0));
    prev = 64'h0000_0002_0000_000E;

    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      run_op(o, a, b, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
